pc_sequencer: RTL
=================

# pc_sequencer

- Parametrised next-generation program counter for the core's fetch stage.
- Holds the current fetch address and chooses each next PC from reset, trap, redirect, stall or sequential increment, in fixed priority.
- Presents the PC to instruction memory over a valid/ready handshake and rejects misaligned redirect targets.
- Sits between the branch/trap logic and instruction fetch, and replaces the fixed 32-bit single-input program counter.

## Interface
- `XLEN`, 32: PC width in bits.
- `RESET_VECTOR`, 0: value loaded into the PC while reset is asserted.
- `IALIGN`, 32: instruction alignment in bits; 32 gives a step of 4, 16 gives a step of 2 for compressed instructions.

- `clk` in 1: clock; all state updates on the falling edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hold the PC. Ignored when `trap_req` or `redirect_valid` is high.
- `redirect_valid` in 1: load `redirect_target` (branch or jump).
- `redirect_target` in XLEN: redirect address.
- `trap_req` in 1: load `trap_vector`.
- `trap_vector` in XLEN: trap handler address; its low bits below the step are forced to 0.
- `fetch_ready` in 1: instruction memory accepts `pc_out`.
- `fetch_valid` out 1: `pc_out` is a valid fetch request.
- `pc_out` out XLEN: current PC.
- `pc_plus` out XLEN: `pc_out` + step, modulo 2^XLEN (combinational).
- `misaligned` out 1: one-cycle pulse, a redirect target was rejected.
- `bad_addr` out XLEN: the last rejected redirect target.

## Operation
- States: BOOT, RUN, HALT.
- Reset values: state BOOT, `pc_out`=RESET_VECTOR, `fetch_valid`=0, `misaligned`=0, `bad_addr`=0.
  - These values appear immediately on reset assertion, with no clock edge needed, and hold while reset is high.
- BOOT: after reset is released, the first falling edge moves to RUN. `pc_out` is unchanged.
- RUN: `fetch_valid`=1. Next-PC priority, evaluated at each falling edge:
  1. `trap_req`: load `trap_vector` with its alignment bits cleared.
  2. `redirect_valid` with an aligned target: load `redirect_target`.
  3. `redirect_valid` with a misaligned target: PC unchanged; `bad_addr` takes the target; `misaligned` pulses for one cycle; state goes to HALT.
     - Misaligned means `target[1:0]`≠0 when IALIGN=32, or `target[0]`≠0 when IALIGN=16.
  4. `stall`, or `fetch_ready` low: hold the PC.
  5. Otherwise: load `pc_plus`. The increment wraps, so 0xFFFF_FFFC advances to 0x0000_0000.
- A redirect or trap takes effect even when `fetch_ready` is low; the pending request is dropped.
- HALT: `fetch_valid`=0 and the PC holds. Only `trap_req` leaves HALT: it loads `trap_vector` and returns to RUN. `redirect_valid` and `stall` are ignored.
- Reset asserted in any state, including mid-handshake or during HALT, returns immediately to the reset values above.

## Timing
- All registers update on the falling edge of `clk`; nothing changes on the rising edge.
- Latency: an input sampled at a falling edge shows on `pc_out` immediately after that edge; no extra pipeline stage.
- `pc_plus` and `fetch_valid` are combinational from state and `pc_out`, with no path from the inputs.
- Handshake: a fetch transfers on a falling edge where `fetch_valid` and `fetch_ready` are both high. `pc_out` stays stable while `fetch_valid`=1 and `fetch_ready`=0, unless a trap or redirect occurs.
- `misaligned` is registered. It is high for exactly the one cycle following the rejecting edge.
- Reset release takes effect at the next falling edge. At least one BOOT cycle always passes before the first fetch.

## Structure
- Shared definitions file:
  - state encodings (BOOT, RUN, HALT);
  - the next-PC select encoding (TRAP, REDIR, HOLD, SEQ);
  - a step-size constant derived from IALIGN.
- One sub-module, `pc_next_mux`: purely combinational. It takes the select, `pc_out`, `pc_plus`, `redirect_target` and the aligned `trap_vector`, and outputs the next PC plus a misalignment flag. The top level holds the FSM and registers.

## Test plan
- Async reset:
  - Assert reset with the clock idle → `pc_out`=RESET_VECTOR (0) and `fetch_valid`=0 with no clock edge.
  - Toggle the clock twice with reset high → still 0.
- Boot and increment: release reset, `fetch_ready`=1.
  - 1st falling edge → `pc_out`=0 and `fetch_valid`=1.
  - Next edges → 4, 8, 12.
  - No change on rising edges.
- Stall and backpressure, from `pc_out`=0x10:
  - `stall`=1 for 2 edges → stays 0x10.
  - `fetch_ready`=0 → stays 0x10.
  - Both released → 0x14.
- Priority: at one edge drive `stall`=1, `redirect_valid`=1 with target 0x200, and `trap_req`=1 with vector 0x103 → `pc_out`=0x100.
  - Next edge with only redirect to 0x200 → 0x200.
- Misaligned redirect, IALIGN=32, from 0x40: redirect to 0x202 →
  - `pc_out` stays 0x40;
  - `misaligned`=1 for one cycle;
  - `bad_addr`=0x202;
  - `fetch_valid`=0.
  - Then `trap_req` with vector 0x80 → `pc_out`=0x80 and `fetch_valid`=1.
  - Repeat with IALIGN=16: target 0x202 is accepted.
- Wrap and mid-operation reset:
  - From 0xFFFF_FFFC, one increment → 0x0000_0000.
  - Assert reset mid-handshake (`fetch_ready`=0) → immediately 0 with `fetch_valid`=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM states,
// next-PC select codes and the instruction step derived from the alignment.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_TRAP  = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_HOLD  = 2'd2,
    SEL_SEQ   = 2'd3
  } sel_e;

  localparam int unsigned DEFAULT_IALIGN = 32;

  // Byte step between sequential instructions (4 for IALIGN=32, 2 for 16).
  function automatic int unsigned step_bytes(input int unsigned ialign);
    return ialign / 8;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector; also flags redirect targets that do not
// sit on an instruction boundary.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = DEFAULT_IALIGN
) (
  input  sel_e            sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] trap_aligned,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(step_bytes(IALIGN) - 1);

  assign misaligned = |(redirect_target & ALIGN_MASK);

  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_TRAP:  next_pc = trap_aligned;
      // A rejected redirect leaves the PC where it was.
      SEL_REDIR: next_pc = misaligned ? pc : redirect_target;
      SEL_HOLD:  next_pc = pc;
      SEL_SEQ:   next_pc = pc_plus;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: BOOT/RUN/HALT FSM, falling-edge registers and
// a valid/ready request toward instruction memory.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = DEFAULT_IALIGN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  localparam int unsigned     STEP       = step_bytes(IALIGN);
  localparam logic [XLEN-1:0] STEP_VEC   = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  state_e          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] bad_addr_reg, bad_addr_next;
  logic            misaligned_reg, misaligned_next;
  sel_e            sel;
  logic            target_misaligned;
  logic [XLEN-1:0] trap_aligned;

  assign trap_aligned = trap_vector & ~ALIGN_MASK;
  assign pc_plus      = pc_reg + STEP_VEC;
  assign pc_out       = pc_reg;
  assign misaligned   = misaligned_reg;
  assign bad_addr     = bad_addr_reg;

  pc_next_mux #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_mux (
    .sel             (sel),
    .pc              (pc_reg),
    .pc_plus         (pc_plus),
    .redirect_target (redirect_target),
    .trap_aligned    (trap_aligned),
    .next_pc         (pc_next),
    .misaligned      (target_misaligned)
  );

  // Everything updates on the falling edge; reset is asynchronous.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_BOOT;
      pc_reg         <= RESET_VECTOR;
      bad_addr_reg   <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      bad_addr_reg   <= bad_addr_next;
      misaligned_reg <= misaligned_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    misaligned_next = 1'b0;
    bad_addr_next   = bad_addr_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (sel == SEL_REDIR && target_misaligned) begin
          state_next      = ST_HALT;
          misaligned_next = 1'b1;
          bad_addr_next   = redirect_target;
        end
      end
      ST_HALT: begin
        if (trap_req) state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Select priority: trap, redirect, hold (stall/backpressure), sequential.
  always_comb begin
    fetch_valid = 1'b0;
    sel         = SEL_HOLD;
    case (state_reg)
      ST_RUN: begin
        fetch_valid = 1'b1;
        if (trap_req)                   sel = SEL_TRAP;
        else if (redirect_valid)        sel = SEL_REDIR;
        else if (stall || !fetch_ready) sel = SEL_HOLD;
        else                            sel = SEL_SEQ;
      end
      ST_HALT: begin
        if (trap_req) sel = SEL_TRAP;
      end
      default: sel = SEL_HOLD;
    endcase
  end

endmodule
